// File: rtl/cpu_mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch (IF) and memory access (MA).
// MA has fixed priority. A starvation counter forces an IF grant after STARVE_LIMIT back-to-back MA wins.
module cpu_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_flush_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,

  input  logic                    ma_req_i,
  input  logic                    ma_we_i,
  input  logic [DATA_WIDTH/8-1:0] ma_be_i,
  input  logic [ADDR_WIDTH-1:0]   ma_addr_i,
  input  logic [DATA_WIDTH-1:0]   ma_wdata_i,
  output logic                    ma_gnt_o,
  output logic                    ma_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ma_rdata_o,

  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int         BE_W       = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Which requester owns the read data returning from memory this cycle.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_MA   = 2'd2
  } resp_e;

  resp_e                 resp_q, resp_d;
  logic [3:0]            starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic if_gnt, ma_gnt;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    if_gnt = 1'b0;
    ma_gnt = 1'b0;
    if (!reset_i) begin
      if (if_req_i && (!ma_req_i || starve_q == STARVE_MAX)) begin
        if_gnt = 1'b1;
      end else if (ma_req_i) begin
        ma_gnt = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_q   <= RESP_NONE;
      starve_q <= 4'd0;
      addr_q   <= '0;
    end else begin
      resp_q   <= resp_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    resp_d   = RESP_NONE;
    starve_d = starve_q;
    addr_d   = addr_q;

    if (if_gnt) begin
      resp_d = RESP_IF;
      addr_d = if_addr_i;
    end else if (ma_gnt) begin
      resp_d = ma_we_i ? RESP_NONE : RESP_MA;
      addr_d = ma_addr_i;
    end

    // The counter only measures IF waiting behind MA; any IF grant or idle IF clears it.
    if (!if_req_i || if_gnt) begin
      starve_d = 4'd0;
    end else if (ma_gnt && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Outputs: the memory port in the grant cycle, and response routing one cycle later.
  always_comb begin
    if_gnt_o    = if_gnt;
    ma_gnt_o    = ma_gnt;
    mem_addr_o  = addr_q;
    mem_we_o    = '0;
    mem_wdata_o = '0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ma_rvalid_o = 1'b0;
    ma_rdata_o  = '0;

    if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end else if (ma_gnt) begin
      mem_addr_o  = ma_addr_i;
      mem_we_o    = ma_we_i ? ma_be_i : {BE_W{1'b0}};
      mem_wdata_o = ma_wdata_i;
    end

    // A flush in the response cycle kills only the fetch response.
    if (resp_q == RESP_IF && !if_flush_i) begin
      if_rvalid_o = 1'b1;
      if_rdata_o  = mem_rdata_i;
    end
    if (resp_q == RESP_MA) begin
      ma_rvalid_o = 1'b1;
      ma_rdata_o  = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a small synchronous byte-writable memory model.
module tb_cpu_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          ma_req_i, ma_we_i, ma_gnt_o, ma_rvalid_o;
  logic [3:0]    ma_be_i;
  logic [AW-1:0] ma_addr_i;
  logic [DW-1:0] ma_wdata_i, ma_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_we_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [256];

  cpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ma_req_i(ma_req_i), .ma_we_i(ma_we_i), .ma_be_i(ma_be_i), .ma_addr_i(ma_addr_i),
    .ma_wdata_i(ma_wdata_i), .ma_gnt_o(ma_gnt_o), .ma_rvalid_o(ma_rvalid_o),
    .ma_rdata_o(ma_rdata_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[64]  = 32'hDEAD_BEEF;
    mem[192] = 32'hFEED_0300;
  end

  // Synchronous-read memory with byte write enables.
  always @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (mem_we_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    mem_rdata_i <= mem[mem_addr_o[9:2]];
  end

  task automatic idle_inputs();
    if_req_i = 0; if_flush_i = 0; ma_req_i = 0; ma_we_i = 0; ma_be_i = 4'h0;
  endtask

  task automatic test_reset();
    reset_i = 1; if_req_i = 1; ma_req_i = 1; ma_we_i = 0; ma_be_i = 4'hF;
    if_flush_i = 0; if_addr_i = 32'h104; ma_addr_i = 32'h0; ma_wdata_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #2;
      checks++;
      if ({if_gnt_o, ma_gnt_o, if_rvalid_o, ma_rvalid_o} !== 4'b0000) begin
        errors++; $display("FAIL reset_ctl: got %b expected 0000", {if_gnt_o, ma_gnt_o, if_rvalid_o, ma_rvalid_o});
      end
      checks++;
      if (mem_we_o !== 4'h0 || mem_addr_o !== 32'h0) begin
        errors++; $display("FAIL reset_mem: we=%h addr=%h expected 0/0", mem_we_o, mem_addr_o);
      end
    end
    @(negedge clk_i); reset_i = 0; #2;
    checks++;
    if (ma_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: ma_gnt=%b if_gnt=%b expected 1/0", ma_gnt_o, if_gnt_o);
    end
    @(negedge clk_i); idle_inputs(); #2;
    checks++;
    if (ma_rvalid_o !== 1'b1 || ma_rdata_o !== 32'hC0DE_0000) begin
      errors++; $display("FAIL reset_first_read: rvalid=%b data=%h expected 1/c0de0000", ma_rvalid_o, ma_rdata_o);
    end
  endtask

  task automatic test_if_only();
    @(negedge clk_i); if_req_i = 1; if_addr_i = 32'h100; #2;
    checks++;
    if (if_gnt_o !== 1'b1 || ma_gnt_o !== 1'b0 || mem_addr_o !== 32'h100 || mem_we_o !== 4'h0) begin
      errors++; $display("FAIL if_only_gnt: gnt=%b addr=%h we=%h expected 1/100/0", if_gnt_o, mem_addr_o, mem_we_o);
    end
    @(negedge clk_i); idle_inputs(); #2;
    checks++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL if_only_resp: rvalid=%b data=%h expected 1/deadbeef", if_rvalid_o, if_rdata_o);
    end
    @(negedge clk_i); #2;
    checks++;
    if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0 || mem_addr_o !== 32'h100) begin
      errors++; $display("FAIL if_only_idle: rvalid=%b data=%h addr=%h expected 0/0/100", if_rvalid_o, if_rdata_o, mem_addr_o);
    end
  endtask

  task automatic test_contention();
    logic [5:0] exp_ma = 6'b101111; // bit k = MA expected in cycle k: M,M,M,M,I,M
    int nma = 0;
    logic prev_ma = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if_req_i = 1; if_addr_i = 32'h104; ma_req_i = 1; ma_we_i = 0;
      ma_addr_i = 32'h200 + 32'(4 * nma); #2;
      checks++;
      if (ma_gnt_o !== exp_ma[k] || if_gnt_o !== !exp_ma[k]) begin
        errors++; $display("FAIL contention_gnt[%0d]: ma=%b if=%b expected ma=%b", k, ma_gnt_o, if_gnt_o, exp_ma[k]);
      end
      if (k > 0) begin
        checks++;
        if (prev_ma) begin
          if (ma_rvalid_o !== 1'b1 || ma_rdata_o !== (32'hC0DE_0000 | 32'(128 + nma - 1))) begin
            errors++; $display("FAIL contention_ma_resp[%0d]: v=%b d=%h", k, ma_rvalid_o, ma_rdata_o);
          end
        end else if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hC0DE_0041) begin
          errors++; $display("FAIL contention_if_resp[%0d]: v=%b d=%h expected 1/c0de0041", k, if_rvalid_o, if_rdata_o);
        end
      end
      prev_ma = exp_ma[k];
      nma += int'(exp_ma[k]);
    end
    @(negedge clk_i); idle_inputs(); #2;
    checks++;
    if (ma_rvalid_o !== 1'b1 || ma_rdata_o !== 32'hC0DE_0084 || if_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL contention_tail: v=%b d=%h expected 1/c0de0084", ma_rvalid_o, ma_rdata_o);
    end
  endtask

  task automatic test_ma_write();
    @(negedge clk_i);
    ma_req_i = 1; ma_we_i = 1; ma_be_i = 4'b0011; ma_wdata_i = 32'h1234_5678; ma_addr_i = 32'h40; #2;
    checks++;
    if (ma_gnt_o !== 1'b1 || mem_we_o !== 4'b0011 || mem_addr_o !== 32'h40 || mem_wdata_o !== 32'h1234_5678) begin
      errors++; $display("FAIL ma_write_port: gnt=%b we=%b addr=%h wd=%h", ma_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i); ma_we_i = 0; ma_be_i = 4'h0; #2;
    checks++;
    if (ma_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL ma_write_no_resp: rvalid=%b expected 0", ma_rvalid_o);
    end
    @(negedge clk_i); idle_inputs(); #2;
    checks++;
    if (ma_rvalid_o !== 1'b1 || ma_rdata_o !== 32'hC0DE_5678) begin
      errors++; $display("FAIL ma_write_readback: v=%b d=%h expected 1/c0de5678", ma_rvalid_o, ma_rdata_o);
    end
  endtask

  task automatic test_flush();
    @(negedge clk_i); if_req_i = 1; if_addr_i = 32'h104; #2;
    checks++;
    if (if_gnt_o !== 1'b1) begin
      errors++; $display("FAIL flush_first_gnt: gnt=%b expected 1", if_gnt_o);
    end
    @(negedge clk_i); if_addr_i = 32'h300; if_flush_i = 1; #2;
    checks++;
    if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0 || if_gnt_o !== 1'b1) begin
      errors++; $display("FAIL flush_kill: v=%b d=%h gnt=%b expected 0/0/1", if_rvalid_o, if_rdata_o, if_gnt_o);
    end
    @(negedge clk_i); idle_inputs(); #2;
    checks++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hFEED_0300) begin
      errors++; $display("FAIL flush_refetch: v=%b d=%h expected 1/feed0300", if_rvalid_o, if_rdata_o);
    end
    @(negedge clk_i); ma_req_i = 1; ma_addr_i = 32'h8; #2;
    @(negedge clk_i); ma_req_i = 0; if_flush_i = 1; #2;
    checks++;
    if (ma_rvalid_o !== 1'b1 || ma_rdata_o !== 32'hC0DE_0002) begin
      errors++; $display("FAIL flush_ma_unaffected: v=%b d=%h expected 1/c0de0002", ma_rvalid_o, ma_rdata_o);
    end
    if_flush_i = 0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i); idle_inputs(); if_req_i = 1; if_addr_i = 32'h0; #2;
    checks++;
    if (if_gnt_o !== 1'b1 || ma_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_t0: gnt=%b", if_gnt_o);
    end
    @(negedge clk_i); if_req_i = 0; ma_req_i = 1; ma_addr_i = 32'h8; #2;
    checks++;
    if (ma_gnt_o !== 1'b1 || if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hC0DE_0000 || ma_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_t1: gnt=%b iv=%b id=%h mv=%b", ma_gnt_o, if_rvalid_o, if_rdata_o, ma_rvalid_o);
    end
    @(negedge clk_i); idle_inputs(); #2;
    checks++;
    if (ma_rvalid_o !== 1'b1 || ma_rdata_o !== 32'hC0DE_0002 || if_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_t2: mv=%b md=%h iv=%b", ma_rvalid_o, ma_rdata_o, if_rvalid_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i); ma_req_i = 1; ma_we_i = 0; ma_addr_i = 32'h8; #2;
    checks++;
    if (ma_gnt_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_gnt: gnt=%b expected 1", ma_gnt_o);
    end
    @(negedge clk_i); ma_req_i = 0; reset_i = 1; #2;
    checks++;
    if (ma_rvalid_o !== 1'b0 || ma_rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_mid_kill: v=%b d=%h expected 0/0", ma_rvalid_o, ma_rdata_o);
    end
    @(negedge clk_i); reset_i = 0; #2;
    checks++;
    if (ma_rvalid_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_mid_after: v=%b addr=%h expected 0/0", ma_rvalid_o, mem_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_contention();
    test_ma_write();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Shares one synchronous-read memory port (the block_rom/RAM port) between the instruction-fetch stage and the memory-access stage. Arbitration is fixed-priority with MA preferred and a starvation guard for IF. Read responses are routed back to whichever requester was granted. An IF flush input discards in-flight fetch responses when a jump redirects the pipeline.

Parameters:
ADDR_WIDTH, 32, width of all addresses
DATA_WIDTH, 32, width of read/write data
STARVE_LIMIT, 4, consecutive MA grants while IF waits before IF is forced (1..15)

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
if_req_i  in  1  fetch read request; held until granted
if_addr_i  in  ADDR_WIDTH  fetch address
if_flush_i  in  1  discard any pending fetch response
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch read data valid
if_rdata_o  out  DATA_WIDTH  fetch read data
ma_req_i  in  1  data request; held until granted
ma_we_i  in  1  1=write, 0=read
ma_be_i  in  DATA_WIDTH/8  byte enables (writes)
ma_addr_i  in  ADDR_WIDTH  data address
ma_wdata_i  in  DATA_WIDTH  write data
ma_gnt_o  out  1  data request accepted this cycle
ma_rvalid_o  out  1  data read data valid
ma_rdata_o  out  DATA_WIDTH  data read data
mem_addr_o  out  ADDR_WIDTH  memory port address
mem_we_o  out  DATA_WIDTH/8  memory byte write enables
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data, valid one cycle after address

Behaviour:
- Reset (async, while reset_i=1): gnts 0, rvalids 0, rdata 0, mem_we_o 0, mem_addr_o 0, starve counter 0, response state RESP_NONE. No grants while reset_i is high.
- Grant is combinational from requests and registered state. At most one grant per cycle.
- Priority: MA wins when both request, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- starve_cnt (4-bit): +1 on a cycle with ma_gnt_o=1 and if_req_i=1. Cleared on if_gnt_o=1 or when if_req_i=0. Saturates at STARVE_LIMIT.
- Memory port in the grant cycle: IF grant -> mem_addr_o=if_addr_i, mem_we_o=0. MA grant -> mem_addr_o=ma_addr_i, mem_we_o = ma_we_i ? ma_be_i : 0, mem_wdata_o=ma_wdata_i. No grant -> mem_we_o=0, address holds its last value.
- Response state register: RESP_NONE / RESP_IF / RESP_MA, loaded each cycle. RESP_IF on an IF grant; RESP_MA on an MA read grant; RESP_NONE otherwise. MA writes produce no response.
- Responses one cycle after grant:
  - RESP_IF -> if_rvalid_o=1 and if_rdata_o=mem_rdata_i, unless if_flush_i=1 this cycle.
  - RESP_MA -> ma_rvalid_o=1 and ma_rdata_o=mem_rdata_i.
  - rdata outputs are 0 when the matching rvalid is 0.
- Fully pipelined: a new grant is allowed in the same cycle a response is delivered, giving 1 access per cycle of throughput.
- Flush:
  - if_flush_i=1 in the same cycle as if_req_i: an IF grant is still permitted; its response is killed only if the flush is asserted in the response cycle.
  - Flush has no effect on MA.
- A request dropped before grant is a protocol violation; no grant is issued for it.
- Reset asserted mid-access: the pending response is lost and no rvalid follows deassertion.

Test Plan:
- Reset: hold reset_i 3 cycles with both reqs high -> all gnt/rvalid 0, mem_we_o=0. Release -> ma_gnt_o=1 on the first cycle.
- IF-only: if_req_i=1, if_addr_i=0x100, memory returns 0xDEADBEEF next cycle -> if_gnt_o=1 at t, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF at t+1.
- Contention: both request continuously, MA reads at 0x200.. -> ma_gnt_o for 4 cycles, then if_gnt_o on the 5th, counter back to 0, then MA again.
- MA write: ma_we_i=1, ma_be_i=4'b0011, ma_wdata_i=0x12345678, addr 0x40 -> mem_we_o=4'b0011, mem_addr_o=0x40 in the grant cycle, no ma_rvalid_o next cycle.
- Flush: IF granted at t, if_flush_i=1 at t+1 -> if_rvalid_o=0 at t+1. A new IF grant at t+1 to 0x300 yields if_rvalid_o=1 at t+2.
- Back-to-back alternation: IF read 0x0 at t, MA read 0x8 at t+1 -> if_rvalid_o at t+1, ma_rvalid_o at t+2, never both high at once.
